// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter for the single register-file write port, one-cycle registered write.
// Define RF_ARB_LOCK_EN to add req_lock and the ARB/LOCKED ownership FSM.
module rf_wr_arbiter #(
    parameter int NREQ   = 2,
    parameter int DWIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [3*NREQ-1:0]      req_reg,
    input  logic [DWIDTH*NREQ-1:0] req_data,
`ifdef RF_ARB_LOCK_EN
    input  logic [NREQ-1:0]        req_lock,
`endif
    output logic [NREQ-1:0]        req_ready,
    input  logic                   rf_stall,
    output logic [7:0]             wr_en,
    output logic [DWIDTH-1:0]      wr_data,
    output logic [2:0]             wr_reg,
    output logic                   err,
    output logic                   dbg_locked,
    output logic [1:0]             dbg_ptr
);
    typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [NREQ-1:0]   pend_q, pend_d;
    logic              err_q;
    logic [7:0]        wr_en_q;
    logic [DWIDTH-1:0] wr_data_q;
    logic [2:0]        wr_reg_q;

    // Request vectors padded to 4 bits so a 2-bit index is always in range.
    logic [3:0]        valid_ext, lock_ext, elig_ext, grant_ext, drop_ext;
    logic [1:0]        cand, win, win_next;
    logic              found, xfer, viol;
    logic [2:0]        sel_reg;
    logic [DWIDTH-1:0] sel_data;

    always_comb begin
        valid_ext = '0;
        valid_ext[NREQ-1:0] = req_valid;
        lock_ext = '0;
`ifdef RF_ARB_LOCK_EN
        lock_ext[NREQ-1:0] = req_lock;
`endif
        drop_ext = '0;
        drop_ext[NREQ-1:0] = pend_q & ~req_valid;
        elig_ext = (state_q == LOCKED) ? (valid_ext & (4'b0001 << owner_q)) : valid_ext;
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = 2'((int'(ptr_q) + k) % NREQ);
            if (!found && elig_ext[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        xfer      = found & ~rst & ~rf_stall;
        grant_ext = '0;
        if (xfer) begin
            grant_ext[win] = 1'b1;
        end
        win_next = (win == 2'(NREQ - 1)) ? 2'd0 : win + 2'd1;
    end

    assign req_ready = grant_ext[NREQ-1:0];

    always_comb begin
        sel_reg  = '0;
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win == 2'(k)) begin
                sel_reg  = req_reg[3*k +: 3];
                sel_data = req_data[DWIDTH*k +: DWIDTH];
            end
        end
    end

    // A requester still waiting after this edge must keep its valid high next cycle.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        pend_d  = req_valid & ~req_ready;
        viol    = 1'b0;
        case (state_q)
            ARB: begin
                viol = |drop_ext;
                if (xfer) begin
                    ptr_d = win_next;
                    if (lock_ext[win]) begin
                        state_d = LOCKED;
                        owner_d = win;
                    end
                end
            end
            LOCKED: begin
                viol = drop_ext[owner_q];
                if (xfer) begin
                    if (!lock_ext[win]) begin
                        state_d = ARB;
                        ptr_d   = win_next;
                    end
                end else if (drop_ext[owner_q]) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB;
            owner_q   <= '0;
            ptr_q     <= '0;
            pend_q    <= '0;
            err_q     <= 1'b0;
            wr_en_q   <= 8'h00;
            wr_data_q <= '0;
            wr_reg_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            pend_q  <= pend_d;
            err_q   <= err_q | viol;
            wr_en_q <= xfer ? (8'h01 << sel_reg) : 8'h00;
            if (xfer) begin
                wr_reg_q  <= sel_reg;
                wr_data_q <= sel_data;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_data    = wr_data_q;
    assign wr_reg     = wr_reg_q;
    assign err        = err_q;
    assign dbg_locked = (state_q == LOCKED);
    assign dbg_ptr    = ptr_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter (NREQ=2, DWIDTH=16) with hand-computed expectations.
module tb_rf_wr_arbiter;
    localparam int NREQ   = 2;
    localparam int DWIDTH = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [3*NREQ-1:0]      req_reg;
    logic [DWIDTH*NREQ-1:0] req_data;
`ifdef RF_ARB_LOCK_EN
    logic [NREQ-1:0]        req_lock;
`endif
    logic [NREQ-1:0]        req_ready;
    logic                   rf_stall;
    logic [7:0]             wr_en;
    logic [DWIDTH-1:0]      wr_data;
    logic [2:0]             wr_reg;
    logic                   err;
    logic                   dbg_locked;
    logic [1:0]             dbg_ptr;

    int n_cmp = 0;
    int n_bad = 0;

    rf_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_reg    (req_reg),
        .req_data   (req_data),
`ifdef RF_ARB_LOCK_EN
        .req_lock   (req_lock),
`endif
        .req_ready  (req_ready),
        .rf_stall   (rf_stall),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_reg     (wr_reg),
        .err        (err),
        .dbg_locked (dbg_locked),
        .dbg_ptr    (dbg_ptr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [2:0] r0, input logic [15:0] d0,
                         input logic [2:0] r1, input logic [15:0] d1);
        req_valid = v;
        req_reg   = {r1, r0};
        req_data  = {d1, d0};
    endtask

    initial begin
        rst      = 1'b1;
        rf_stall = 1'b0;
`ifdef RF_ARB_LOCK_EN
        req_lock = 2'b00;
`endif
        drive(2'b11, 3'd1, 16'h1111, 3'd2, 16'h2222);

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_wr_en", 32'(wr_en), 32'h00);
        check("rst_wr_data", 32'(wr_data), 32'h0);
        check("rst_wr_reg", 32'(wr_reg), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_ptr", 32'(dbg_ptr), 32'h0);
        check("rst_locked", 32'(dbg_locked), 32'h0);

        // Single write from requester 0
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        rst = 1'b0;
        tick();
        drive(2'b01, 3'd5, 16'h1234, 3'd0, 16'h0);
        settle();
        check("t1_ready", 32'(req_ready), 32'h1);
        tick();
        check("t1_wr_en", 32'(wr_en), 32'h20);
        check("t1_wr_reg", 32'(wr_reg), 32'h5);
        check("t1_wr_data", 32'(wr_data), 32'h1234);
        check("t1_ptr", 32'(dbg_ptr), 32'h1);
        drive(2'b00, 3'd5, 16'h1234, 3'd0, 16'h0);
        tick();
        check("t1_wr_en_off", 32'(wr_en), 32'h00);
        check("t1_data_hold", 32'(wr_data), 32'h1234);
        check("t1_reg_hold", 32'(wr_reg), 32'h5);
        check("t1_err", 32'(err), 32'h0);

        // Round robin with both requesters valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t2_ptr0", 32'(dbg_ptr), 32'h0);
        drive(2'b11, 3'd2, 16'hA000, 3'd6, 16'hB000);
        settle();
        check("t2_g1_ready", 32'(req_ready), 32'h1);
        tick();
        check("t2_g1_wr_en", 32'(wr_en), 32'h04);
        check("t2_g1_data", 32'(wr_data), 32'hA000);
        drive(2'b11, 3'd3, 16'hA001, 3'd6, 16'hB000);
        settle();
        check("t2_g2_ready", 32'(req_ready), 32'h2);
        tick();
        check("t2_g2_wr_en", 32'(wr_en), 32'h40);
        check("t2_g2_reg", 32'(wr_reg), 32'h6);
        check("t2_g2_data", 32'(wr_data), 32'hB000);
        check("t2_wrap_ptr", 32'(dbg_ptr), 32'h0);
        drive(2'b11, 3'd3, 16'hA001, 3'd7, 16'hB001);
        settle();
        check("t2_g3_ready", 32'(req_ready), 32'h1);
        tick();
        check("t2_g3_wr_en", 32'(wr_en), 32'h08);
        check("t2_g3_data", 32'(wr_data), 32'hA001);
        settle();
        check("t2_g4_ready", 32'(req_ready), 32'h2);
        tick();
        check("t2_g4_wr_en", 32'(wr_en), 32'h80);
        check("t2_g4_data", 32'(wr_data), 32'hB001);
        check("t2_g4_ptr", 32'(dbg_ptr), 32'h0);

        // Stall blocks grants for three cycles
        rf_stall = 1'b1;
        settle();
        check("t3_stall_ready", 32'(req_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_stall_wr_en", 32'(wr_en), 32'h00);
            check("t3_stall_ready_hold", 32'(req_ready), 32'h0);
            check("t3_stall_err", 32'(err), 32'h0);
        end
        check("t3_stall_ptr", 32'(dbg_ptr), 32'h0);
        rf_stall = 1'b0;
        settle();
        check("t3_release_ready", 32'(req_ready), 32'h1);
        tick();
        check("t3_release_wr_en", 32'(wr_en), 32'h08);
        check("t3_release_data", 32'(wr_data), 32'hA001);

        // Requester 1 drops valid while still pending
        settle();
        check("t4_pre_ready", 32'(req_ready), 32'h2);
        tick();
        check("t4_pre_wr_en", 32'(wr_en), 32'h80);
        settle();
        check("t4_x_ready", 32'(req_ready), 32'h1);
        tick();
        drive(2'b01, 3'd3, 16'hA001, 3'd7, 16'hB001);
        settle();
        check("t4_y_err", 32'(err), 32'h0);
        check("t4_y_ready", 32'(req_ready), 32'h1);
        tick();
        check("t4_err_set", 32'(err), 32'h1);
        check("t4_wr_en", 32'(wr_en), 32'h08);
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        tick();
        tick();
        check("t4_err_sticky", 32'(err), 32'h1);
        rst = 1'b1;
        tick();
        check("t4_err_clear", 32'(err), 32'h0);
        rst = 1'b0;

        // Reset the cycle after a transfer
        drive(2'b11, 3'd1, 16'hC000, 3'd4, 16'hC001);
        settle();
        check("t5_ready", 32'(req_ready), 32'h1);
        tick();
        check("t5_wr_en", 32'(wr_en), 32'h02);
        check("t5_ptr", 32'(dbg_ptr), 32'h1);
        rst = 1'b1;
        settle();
        check("t5_rst_ready", 32'(req_ready), 32'h0);
        tick();
        check("t5_rst_wr_en", 32'(wr_en), 32'h00);
        check("t5_rst_ptr", 32'(dbg_ptr), 32'h0);
        rst = 1'b0;
        settle();
        check("t5_post_ready", 32'(req_ready), 32'h1);
        tick();
        check("t5_post_wr_en", 32'(wr_en), 32'h02);
        check("t5_post_data", 32'(wr_data), 32'hC000);
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        tick();

`ifdef RF_ARB_LOCK_EN
        // Requester 1 locks the port for three writes
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(2'b10, 3'd0, 16'h0, 3'd2, 16'hD000);
        req_lock = 2'b10;
        settle();
        check("t6_l1_ready", 32'(req_ready), 32'h2);
        tick();
        check("t6_l1_wr_en", 32'(wr_en), 32'h04);
        check("t6_l1_locked", 32'(dbg_locked), 32'h1);
        check("t6_l1_ptr", 32'(dbg_ptr), 32'h0);
        drive(2'b11, 3'd1, 16'hD100, 3'd2, 16'hD001);
        settle();
        check("t6_l2_ready", 32'(req_ready), 32'h2);
        tick();
        check("t6_l2_wr_en", 32'(wr_en), 32'h04);
        check("t6_l2_data", 32'(wr_data), 32'hD001);
        check("t6_l2_locked", 32'(dbg_locked), 32'h1);
        req_lock = 2'b00;
        drive(2'b11, 3'd1, 16'hD100, 3'd3, 16'hD002);
        settle();
        check("t6_l3_ready", 32'(req_ready), 32'h2);
        tick();
        check("t6_l3_wr_en", 32'(wr_en), 32'h08);
        check("t6_l3_locked", 32'(dbg_locked), 32'h0);
        check("t6_l3_ptr", 32'(dbg_ptr), 32'h0);
        settle();
        check("t6_r0_ready", 32'(req_ready), 32'h1);
        tick();
        check("t6_r0_wr_en", 32'(wr_en), 32'h02);
        check("t6_r0_data", 32'(wr_data), 32'hD100);
        check("t6_err", 32'(err), 32'h0);
        drive(2'b00, 3'd0, 16'h0, 3'd0, 16'h0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
